div_iter_ctl: RTL and testbench

Next-generation iterative integer divider that replaces the fixed 1-bit-per-step unsigned divider.
- Generalised in width and radix (1, 2 or 4 quotient bits per cycle); signed/unsigned selected per operation.
- Valid/ready handshake on both sides, with results held until consumed.
- Divide-by-zero and signed-overflow fast paths; synchronous flush.
- Sits between the execute-stage issue logic and the writeback arbiter.

---
 rtl/div_iter_ctl.sv | 154 +++++++++++++++
 tb/tb_div_iter_ctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_ctl.sv
// Iterative restoring divider: signed/unsigned, BITS_PER_CYCLE quotient bits per
// ITER cycle, valid/ready on both sides, divide-by-zero and MIN/-1 fast paths.
module div_iter_ctl #(
  parameter int DATAWIDTH      = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_signed,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow,
  output logic                 busy
);

  localparam int W  = DATAWIDTH;
  localparam int N  = DATAWIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_signed, r_qneg, r_rneg, r_dbz, r_ovf;
  logic [W-1:0]    r_a, r_b, r_d, r_quot, r_rem;
  logic [2*W-1:0]  r_pr;
  logic [CW-1:0]   r_cnt;

  logic            w_accept, w_a_neg, w_b_neg, w_dbz, w_ovf;
  logic [W-1:0]    w_a_abs, w_b_abs, w_q_fix, w_r_raw, w_r_fix;
  logic [2*W-1:0]  w_pr_nxt;
  logic [W:0]      w_hi;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_a_neg  = r_signed && r_a[W-1];
  assign w_b_neg  = r_signed && r_b[W-1];
  assign w_a_abs  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_abs  = w_b_neg ? (~r_b + 1'b1) : r_b;
  assign w_dbz    = (r_b == '0);
  assign w_ovf    = r_signed && (r_a == MIN) && (r_b == '1);

  // Upper half holds the running remainder, lower half shifts dividend bits out
  // and quotient bits in. The shifted-out MSB is kept in w_hi so the compare
  // sees the full W+1-bit value.
  always_comb begin
    w_pr_nxt = r_pr;
    w_hi     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_hi     = w_pr_nxt[2*W-1:W-1];
      w_pr_nxt = {w_pr_nxt[2*W-2:0], 1'b0};
      if (w_hi >= {1'b0, r_d}) begin
        w_hi                = w_hi - {1'b0, r_d};
        w_pr_nxt[2*W-1:W]   = w_hi[W-1:0];
        w_pr_nxt[0]         = 1'b1;
      end
    end
  end

  assign w_r_raw = r_pr[2*W-1:W];
  assign w_q_fix = r_qneg ? (~r_pr[W-1:0] + 1'b1) : r_pr[W-1:0];
  assign w_r_fix = (r_rneg && (w_r_raw != '0)) ? (~w_r_raw + 1'b1) : w_r_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_PREP;
      S_PREP: w_state_nxt = (w_dbz || w_ovf) ? S_DONE : S_ITER;
      S_ITER: if (r_cnt == LAST) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_pr     <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= dividend;
        r_b      <= divisor;
        r_signed <= op_signed;
        r_dbz    <= 1'b0;
        r_ovf    <= 1'b0;
      end
      // quotient/remainder only change on the edge entering DONE
      if (!flush) begin
        case (r_state)
          S_PREP: begin
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            if (w_dbz) begin
              r_dbz  <= 1'b1;
              r_quot <= '1;
              r_rem  <= r_a;
            end else if (w_ovf) begin
              r_ovf  <= 1'b1;
              r_quot <= MIN;
              r_rem  <= '0;
            end else begin
              r_pr  <= {{W{1'b0}}, w_a_abs};
              r_d   <= w_b_abs;
              r_cnt <= '0;
            end
          end
          S_ITER: begin
            r_pr  <= w_pr_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
          S_FIX: begin
            r_quot <= w_q_fix;
            r_rem  <= w_r_fix;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_div_iter_ctl.sv
// Bench for div_iter_ctl: an 8-bit radix-1 and a 64-bit radix-4 instance, each
// checked every cycle against an arithmetic reference model.
module tb_div_iter_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       f8 = 0, iv8 = 0, s8 = 0, or8 = 0;
  logic       ir8, ov8, dz8, of8, bz8;
  logic [7:0] a8 = 0, b8 = 0, q8, r8;

  logic        f64 = 0, iv64 = 0, s64 = 0, or64 = 0;
  logic        ir64, ov64, dz64, of64, bz64;
  logic [63:0] a64 = 0, b64 = 0, q64, r64;

  div_iter_ctl #(.DATAWIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(iv8), .in_ready(ir8),
    .op_signed(s8), .dividend(a8), .divisor(b8), .out_valid(ov8), .out_ready(or8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(of8), .busy(bz8));

  div_iter_ctl #(.DATAWIDTH(64), .BITS_PER_CYCLE(4)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(f64), .in_valid(iv64), .in_ready(ir64),
    .op_signed(s64), .dividend(a64), .divisor(b64), .out_valid(ov64), .out_ready(or64),
    .quotient(q64), .remainder(r64), .div_by_zero(dz64), .overflow(of64), .busy(bz64));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended / masked operands.
  function automatic void ref_div(input int w, input bit sgn, input logic [63:0] ai,
                                  input logic [63:0] bi, output logic [63:0] q,
                                  output logic [63:0] r, output bit dz, output bit ov);
    logic [63:0] mask, a, b;
    longint sa, sb, mn;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a  = ai & mask;
    b  = bi & mask;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    mn = -(longint'(1) << (w - 1));
    dz = 0;
    ov = 0;
    if (b == 0) begin
      dz = 1; q = mask; r = a;
    end else if (sgn && sa == mn && sb == -1) begin
      ov = 1; q = 64'd1 << (w - 1); r = 0;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    q = q & mask;
    r = r & mask;
  endfunction

  bit          e8_v = 0, e8_dz, e8_of, e64_v = 0, e64_dz, e64_of;
  logic [63:0] e8_q, e8_r, e64_q, e64_r;
  logic [63:0] l8_q = 0, l8_r = 0, l64_q = 0, l64_r = 0;

  // Per-cycle compare: presented results must match the model; outside DONE the
  // result registers must hold the last presented value (0 after reset).
  always @(negedge clk) begin
    if (!rst_n) begin
      l8_q <= 0; l8_r <= 0; l64_q <= 0; l64_r <= 0;
      chk("rst q8", q8, 0);
      chk("rst q64", q64, 0);
      chk("rst ov64", ov64, 0);
    end else begin
      if (ov8) begin
        chk("ov8 expected", e8_v, 1);
        chk("q8", q8, e8_q);
        chk("r8", r8, e8_r);
        chk("dz8", dz8, e8_dz);
        chk("of8", of8, e8_of);
        chk("ir8 in DONE", ir8, 0);
        l8_q <= q8; l8_r <= r8;
      end else begin
        chk("q8 hold", q8, l8_q);
        chk("r8 hold", r8, l8_r);
      end
      chk("busy8", bz8, !ir8);
      if (ov64) begin
        chk("ov64 expected", e64_v, 1);
        chk("q64", q64, e64_q);
        chk("r64", r64, e64_r);
        chk("dz64", dz64, e64_dz);
        chk("of64", of64, e64_of);
        chk("ir64 in DONE", ir64, 0);
        l64_q <= q64; l64_r <= r64;
      end else begin
        chk("q64 hold", q64, l64_q);
        chk("r64 hold", r64, l64_r);
      end
      chk("busy64", bz64, !ir64);
    end
  end

  task automatic drive_in(input bit big, input bit sgn, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    if (big) begin iv64 = 1; s64 = sgn; a64 = a; b64 = b; end
    else begin iv8 = 1; s8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    #1;
    iv8 = 0; iv64 = 0;
    // operands must have been latched at accept
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s8;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; s64 = ~s64;
  endtask

  // One operation; lat = edges after the accept edge until out_valid.
  task automatic run_op(input bit big, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                        input int hold, input bit fl, output logic [63:0] q, output logic [63:0] r,
                        output int lat);
    logic [63:0] eq, er;
    bit ed, eo;
    ref_div(big ? 64 : 8, sgn, a, b, eq, er, ed, eo);
    if (big) begin e64_q = eq; e64_r = er; e64_dz = ed; e64_of = eo; e64_v = 1; end
    else begin e8_q = eq; e8_r = er; e8_dz = ed; e8_of = eo; e8_v = 1; end
    drive_in(big, sgn, a, b);
    lat = 0;
    while (!(big ? ov64 : ov8) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid timeout", big ? ov64 : ov8, 1);
    chk("latency", lat, (ed || eo) ? 1 : (big ? 18 : 10));
    q = big ? q64 : {56'd0, q8};
    r = big ? r64 : {56'd0, r8};
    repeat (hold) @(posedge clk);
    @(negedge clk);
    if (big) begin or64 = 1; f64 = fl; end else begin or8 = 1; f8 = fl; end
    @(posedge clk);
    #1;
    or8 = 0; or64 = 0; f8 = 0; f64 = 0;
    e8_v = 0; e64_v = 0;
    chk("in_ready after DONE", big ? ir64 : ir8, 1);
    chk("out_valid after DONE", big ? ov64 : ov8, 0);
  endtask

  function automatic logic [63:0] rnd_val(input bit big);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = 0;
      1: v = '1;
      2: v = big ? 64'h8000_0000_0000_0000 : 64'h80;
      3: v = 64'($urandom_range(1, 20));
      4: v = v >> $urandom_range(0, 62);
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] q, r;
    bit d, o;
    int lat;

    // model pins
    ref_div(8, 0, 200, 7, q, r, d, o);
    chk("model 200/7 q", q, 28);
    chk("model 200/7 r", r, 4);
    ref_div(8, 1, 64'hF9, 2, q, r, d, o);
    chk("model -7/2 q", q, 64'hFD);
    chk("model -7/2 r", r, 64'hFF);
    ref_div(64, 1, 64'h8000_0000_0000_0000, '1, q, r, d, o);
    chk("model MIN/-1 ov", o, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready8", ir8, 1);
    chk("reset busy64", bz64, 0);
    chk("reset r64", r64, 0);
    chk("reset dz8", dz8, 0);
    rst_n = 1;

    run_op(0, 0, 200, 7, 0, 0, q, r, lat);
    chk("200/7 q", q, 28);  chk("200/7 r", r, 4);  chk("200/7 lat", lat, 10);
    run_op(0, 1, 64'hF9, 2, 1, 0, q, r, lat);
    chk("-7/2 q", q, 64'hFD);  chk("-7/2 r", r, 64'hFF);
    run_op(0, 1, 7, 64'hFE, 0, 0, q, r, lat);
    chk("7/-2 q", q, 64'hFD);  chk("7/-2 r", r, 1);
    run_op(0, 0, 64'hF9, 2, 0, 0, q, r, lat);
    chk("u F9/2 q", q, 124);  chk("u F9/2 r", r, 1);
    run_op(0, 0, 64'h5A, 0, 0, 0, q, r, lat);
    chk("5A/0 q", q, 64'hFF);  chk("5A/0 r", r, 64'h5A);  chk("5A/0 lat", lat, 1);
    run_op(0, 1, 64'h80, 64'hFF, 0, 0, q, r, lat);
    chk("80/FF q", q, 64'h80);  chk("80/FF r", r, 0);
    run_op(1, 0, '1, 3, 0, 0, q, r, lat);
    chk("max/3 q", q, 64'h5555_5555_5555_5555);  chk("max/3 r", r, 0);  chk("max/3 lat", lat, 18);

    // 20 cycles of back-pressure in DONE
    run_op(1, 1, -64'sd1000, 7, 20, 0, q, r, lat);
    chk("-1000/7 q", q, -64'sd142);  chk("-1000/7 r", r, -64'sd6);

    // flush in ITER (counter == 3); result must never appear
    drive_in(0, 0, 50, 3);
    repeat (4) @(posedge clk);
    @(negedge clk); f8 = 1;
    @(posedge clk); #1; f8 = 0;
    chk("flush busy", bz8, 0);
    chk("flush in_ready", ir8, 1);
    repeat (12) @(posedge clk);
    chk("flush no result", ov8, 0);
    // flush beats in_valid in IDLE
    @(negedge clk); f8 = 1; iv8 = 1; a8 = 9; b8 = 3;
    @(posedge clk); #1; f8 = 0; iv8 = 0;
    chk("flush+in_valid not accepted", bz8, 0);
    run_op(0, 0, 100, 10, 0, 0, q, r, lat);
    chk("100/10 q", q, 10);  chk("100/10 r", r, 0);
    // flush together with out_ready in DONE
    run_op(1, 0, 1000, 7, 2, 1, q, r, lat);
    chk("flush DONE q", q, 142);

    // asynchronous reset mid-ITER
    drive_in(1, 0, '1, 7);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 0; #1;
    chk("async rst q64", q64, 0);
    chk("async rst r64", r64, 0);
    chk("async rst busy64", bz64, 0);
    chk("async rst in_ready64", ir64, 1);
    chk("async rst q8", q8, 0);
    chk("async rst ov64", ov64, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 300; i++)
      run_op(0, 1'($urandom), rnd_val(0), rnd_val(0), $urandom_range(0, 3),
             $urandom_range(0, 15) == 0, q, r, lat);
    for (int i = 0; i < 1200; i++)
      run_op(1, 1'($urandom), rnd_val(1), rnd_val(1), $urandom_range(0, 3),
             $urandom_range(0, 15) == 0, q, r, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
